// File: rtl/pedc_pkg.sv
// +-- pedc_pkg : state encoding and default sizes shared by the PEDC blocks -- Rev 1.0 --+
`default_nettype none

package pedc_pkg;

  localparam int unsigned PEDC_N_PE  = 4;
  localparam int unsigned PEDC_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } pedc_state_e;

  function automatic logic pedc_is_phase(input pedc_state_e s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pedc_phase_counter.sv
// +-- pedc_phase_counter : loadable down-counter, terminal at 1, falling-edge -- Rev 1.0 --+
`default_nettype none

module pedc_phase_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_terminal = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/pedc_sequencer.sv
// +-- pedc_sequencer : LOAD/RUN/DRAIN/DONE dataflow controller for N_PE PE channels --+
// +-- Rev 1.0                                                                          --+
`default_nettype none

module pedc_sequencer
  import pedc_pkg::*;
#(
  parameter int unsigned N_PE         = PEDC_N_PE,
  parameter int unsigned CNT_W        = PEDC_CNT_W,
  parameter int unsigned LOAD_CYCLES  = 9,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             PEDC_SEQUENCER_Clk,
  input  logic             PEDC_SEQUENCER_Reset,
  input  logic             PEDC_SEQUENCER_Start_Routine,
  input  logic             PEDC_SEQUENCER_Stop_Routine,
  input  logic [CNT_W-1:0] PEDC_SEQUENCER_Run_Length,
  input  logic [N_PE-1:0]  PEDC_SEQUENCER_Ch_Mask,
  input  logic             PEDC_SEQUENCER_Continuous,
  output logic [N_PE-1:0]  PEDC_SEQUENCER_PE_Reset_n,
  output logic [N_PE-1:0]  PEDC_SEQUENCER_Set_Signal_En,
  output logic             PEDC_SEQUENCER_Load_En,
  output logic             PEDC_SEQUENCER_Busy,
  output logic             PEDC_SEQUENCER_Done,
  output logic [CNT_W-1:0] PEDC_SEQUENCER_Cycle_Count
);

  localparam logic [CNT_W-1:0] c_load_len  = CNT_W'(LOAD_CYCLES);
  localparam logic [CNT_W-1:0] c_drain_len = CNT_W'(DRAIN_CYCLES);

  pedc_state_e      r_state;
  logic [CNT_W-1:0] r_run_len;
  logic [N_PE-1:0]  r_mask;
  logic             r_cont;

  pedc_state_e      w_next_state;
  pedc_state_e      w_first_phase;
  logic             w_inputs_valid;
  logic             w_latch;
  logic             w_terminal;
  logic [CNT_W-1:0] w_next_len;
  logic [N_PE-1:0]  w_next_mask;
  logic [CNT_W-1:0] w_load_val;

  always_comb begin
    w_inputs_valid = (PEDC_SEQUENCER_Run_Length != '0) && (PEDC_SEQUENCER_Ch_Mask != '0);
    w_first_phase  = (LOAD_CYCLES != 0) ? ST_LOAD : ST_RUN;
    w_next_state   = r_state;
    w_latch        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PEDC_SEQUENCER_Start_Routine && w_inputs_valid) begin
          w_next_state = w_first_phase;
          w_latch      = 1'b1;
        end
      end
      ST_LOAD:  if (w_terminal) w_next_state = ST_RUN;
      ST_RUN:   if (w_terminal) w_next_state = (DRAIN_CYCLES != 0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (w_terminal) w_next_state = ST_DONE;
      ST_DONE: begin
        // Continuous restart needs no fresh Start, only valid inputs to relatch.
        if (r_cont && w_inputs_valid) begin
          w_next_state = w_first_phase;
          w_latch      = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Stop overrides everything, including a start request in IDLE.
    if (PEDC_SEQUENCER_Stop_Routine) begin
      w_next_state = ST_IDLE;
      w_latch      = 1'b0;
    end
    w_next_len  = w_latch ? PEDC_SEQUENCER_Run_Length : r_run_len;
    w_next_mask = w_latch ? PEDC_SEQUENCER_Ch_Mask    : r_mask;
    case (w_next_state)
      ST_LOAD:  w_load_val = c_load_len;
      ST_RUN:   w_load_val = w_next_len;
      ST_DRAIN: w_load_val = c_drain_len;
      default:  w_load_val = '0;
    endcase
  end

  pedc_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk        (PEDC_SEQUENCER_Clk),
    .rst        (PEDC_SEQUENCER_Reset),
    .i_load     (w_next_state != r_state),
    .i_load_val (w_load_val),
    .i_en       (pedc_is_phase(r_state)),
    .o_terminal (w_terminal)
  );

  always_ff @(negedge PEDC_SEQUENCER_Clk or posedge PEDC_SEQUENCER_Reset) begin
    if (PEDC_SEQUENCER_Reset) begin
      r_state                      <= ST_IDLE;
      r_run_len                    <= '0;
      r_mask                       <= '0;
      r_cont                       <= 1'b0;
      PEDC_SEQUENCER_PE_Reset_n    <= '0;
      PEDC_SEQUENCER_Set_Signal_En <= '0;
      PEDC_SEQUENCER_Load_En       <= 1'b0;
      PEDC_SEQUENCER_Busy          <= 1'b0;
      PEDC_SEQUENCER_Done          <= 1'b0;
      PEDC_SEQUENCER_Cycle_Count   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_run_len <= PEDC_SEQUENCER_Run_Length;
        r_mask    <= PEDC_SEQUENCER_Ch_Mask;
        r_cont    <= PEDC_SEQUENCER_Continuous;
      end
      // Outputs are decoded from the next state so they align with the state register.
      PEDC_SEQUENCER_PE_Reset_n    <= (w_next_state != ST_IDLE) ? w_next_mask : '0;
      PEDC_SEQUENCER_Set_Signal_En <= (w_next_state == ST_RUN)  ? w_next_mask : '0;
      PEDC_SEQUENCER_Load_En       <= (w_next_state == ST_LOAD);
      PEDC_SEQUENCER_Busy          <= (w_next_state != ST_IDLE);
      PEDC_SEQUENCER_Done          <= (w_next_state == ST_DONE);
      if ((w_next_state == ST_RUN) && (r_state != ST_RUN)) begin
        PEDC_SEQUENCER_Cycle_Count <= '0;
      end else if ((w_next_state == ST_RUN) && (r_state == ST_RUN)) begin
        PEDC_SEQUENCER_Cycle_Count <= PEDC_SEQUENCER_Cycle_Count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pedc_sequencer.sv
// +-- tb_pedc_sequencer : randomized self-checking bench against a timeline model -- Rev 1.0 --+
`default_nettype none

module tb_pedc_sequencer;

  localparam int LC = 9;
  localparam int DC = 3;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic        cont   = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] rl     = '0;
  logic [3:0]  mask   = '0;

  logic [3:0]  pe_rn1, se1, pe_rn2, se2;
  logic        ld1, by1, dn1, ld2, by2, dn2;
  logic [15:0] cc_o1, cc_o2;
  logic [26:0] obs1, obs2;

  int          n_pass   = 0;
  int          n_checks = 0;
  logic [15:0] cc1      = '0;
  logic [15:0] cc2      = '0;

  assign obs1 = {pe_rn1, se1, ld1, by1, dn1, cc_o1};
  assign obs2 = {pe_rn2, se2, ld2, by2, dn2, cc_o2};

  always #5 clk = ~clk;

  pedc_sequencer #(.N_PE(4), .CNT_W(16), .LOAD_CYCLES(LC), .DRAIN_CYCLES(DC)) u_dut (
    .PEDC_SEQUENCER_Clk           (clk),
    .PEDC_SEQUENCER_Reset         (rst),
    .PEDC_SEQUENCER_Start_Routine (start),
    .PEDC_SEQUENCER_Stop_Routine  (stop),
    .PEDC_SEQUENCER_Run_Length    (rl),
    .PEDC_SEQUENCER_Ch_Mask       (mask),
    .PEDC_SEQUENCER_Continuous    (cont),
    .PEDC_SEQUENCER_PE_Reset_n    (pe_rn1),
    .PEDC_SEQUENCER_Set_Signal_En (se1),
    .PEDC_SEQUENCER_Load_En       (ld1),
    .PEDC_SEQUENCER_Busy          (by1),
    .PEDC_SEQUENCER_Done          (dn1),
    .PEDC_SEQUENCER_Cycle_Count   (cc_o1)
  );

  pedc_sequencer #(.N_PE(4), .CNT_W(16), .LOAD_CYCLES(0), .DRAIN_CYCLES(0)) u_dut_nophase (
    .PEDC_SEQUENCER_Clk           (clk),
    .PEDC_SEQUENCER_Reset         (rst),
    .PEDC_SEQUENCER_Start_Routine (start2),
    .PEDC_SEQUENCER_Stop_Routine  (1'b0),
    .PEDC_SEQUENCER_Run_Length    (rl),
    .PEDC_SEQUENCER_Ch_Mask       (mask),
    .PEDC_SEQUENCER_Continuous    (1'b0),
    .PEDC_SEQUENCER_PE_Reset_n    (pe_rn2),
    .PEDC_SEQUENCER_Set_Signal_En (se2),
    .PEDC_SEQUENCER_Load_En       (ld2),
    .PEDC_SEQUENCER_Busy          (by2),
    .PEDC_SEQUENCER_Done          (dn2),
    .PEDC_SEQUENCER_Cycle_Count   (cc_o2)
  );

  // Expected outputs t cycles after a run starts (t=1 is the first cycle after entry),
  // derived purely from phase lengths: LOAD lc, RUN r, DRAIN dc, DONE 1, then IDLE.
  function automatic logic [26:0] model(input int t, input int lc, input int r, input int dc,
                                        input logic [3:0] m, input logic [15:0] prev_cc);
    logic [3:0]  rn, se;
    logic        ld, by, dn;
    logic [15:0] cc;
    rn = '0; se = '0; ld = 1'b0; by = 1'b0; dn = 1'b0; cc = prev_cc;
    if (t <= lc) begin
      rn = m; ld = 1'b1; by = 1'b1;
    end else if (t <= lc + r) begin
      rn = m; se = m; by = 1'b1; cc = 16'(t - lc - 1);
    end else if (t <= lc + r + dc) begin
      rn = m; by = 1'b1; cc = 16'(r - 1);
    end else if (t == lc + r + dc + 1) begin
      rn = m; by = 1'b1; dn = 1'b1; cc = 16'(r - 1);
    end else begin
      cc = 16'(r - 1);
    end
    return {rn, se, ld, by, dn, cc};
  endfunction

  task automatic test_reset;
    #2;
    n_checks++;
    if (obs1 !== 27'd0) $display("FAIL reset_state got %h expected %h", obs1, 27'd0);
    else n_pass++;
    n_checks++;
    if (obs2 !== 27'd0) $display("FAIL reset_state_nophase got %h expected %h", obs2, 27'd0);
    else n_pass++;
    @(posedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [26:0] exp;
    rl = 16'd5; mask = 4'b1010; cont = 1'b0; start = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      @(posedge clk);
      exp = model(t, LC, 5, DC, 4'b1010, cc1);
      n_checks++;
      if (obs1 !== exp) $display("FAIL basic t=%0d got %h expected %h", t, obs1, exp);
      else n_pass++;
      start = 1'b0;
    end
    cc1 = 16'd4;
  endtask

  task automatic test_random_runs;
    logic [26:0] exp;
    int          r, total;
    logic [3:0]  m;
    for (int k = 0; k < 6; k++) begin
      r = int'($urandom_range(1, 12));
      m = 4'($urandom_range(1, 15));
      rl = 16'(r); mask = m; start = 1'b1;
      total = LC + r + DC + 1;
      for (int t = 1; t <= total + 2; t++) begin
        @(posedge clk);
        exp = model(t, LC, r, DC, m, cc1);
        n_checks++;
        if (obs1 !== exp) $display("FAIL random k=%0d t=%0d got %h expected %h", k, t, obs1, exp);
        else n_pass++;
        // Inputs wander while busy; none of it may disturb the run in flight.
        if (t < total) begin
          start = 1'($urandom_range(0, 1));
          rl    = 16'($urandom);
          mask  = 4'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      cc1 = 16'(r - 1);
    end
  endtask

  task automatic test_stop_run;
    logic [26:0] exp;
    logic [3:0]  m;
    m = 4'($urandom_range(1, 15));
    rl = 16'd10; mask = m; start = 1'b1;
    for (int t = 1; t <= LC + 2; t++) begin
      @(posedge clk);
      exp = model(t, LC, 10, DC, m, cc1);
      n_checks++;
      if (obs1 !== exp) $display("FAIL stop_prerun t=%0d got %h expected %h", t, obs1, exp);
      else n_pass++;
      start = 1'b0;
      if (t == LC + 2) stop = 1'b1;
    end
    exp = {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      n_checks++;
      if (obs1 !== exp) $display("FAIL stop_idle t=%0d got %h expected %h", t, obs1, exp);
      else n_pass++;
      stop = 1'b0;
    end
    cc1 = 16'd1;
  endtask

  task automatic test_invalid_start;
    logic [26:0] exp;
    exp = {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, cc1};
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       begin rl = 16'd0; mask = 4'hF; stop = 1'b0; end
        1:       begin rl = 16'd7; mask = 4'h0; stop = 1'b0; end
        default: begin rl = 16'd7; mask = 4'hF; stop = 1'b1; end
      endcase
      start = 1'b1;
      for (int t = 1; t <= 3; t++) begin
        @(posedge clk);
        n_checks++;
        if (obs1 !== exp) $display("FAIL invalid_start s=%0d t=%0d got %h expected %h", s, t, obs1, exp);
        else n_pass++;
      end
      start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic test_continuous;
    logic [26:0] exp;
    logic [3:0]  m;
    int          p;
    m = 4'($urandom_range(1, 15));
    rl = 16'd3; mask = m; cont = 1'b1; start = 1'b1;
    // Continuous dropped mid-way through run 2 is only seen at run 2's DONE: run 3 still happens.
    for (int t = 1; t <= 52; t++) begin
      @(posedge clk);
      if (t <= 48) begin
        p   = (t - 1) / 16;
        exp = model(t - 16 * p, LC, 3, DC, m, (p == 0) ? cc1 : 16'd2);
      end else begin
        exp = model(t - 32, LC, 3, DC, m, 16'd2);
      end
      n_checks++;
      if (obs1 !== exp) $display("FAIL continuous t=%0d got %h expected %h", t, obs1, exp);
      else n_pass++;
      start = 1'b0;
      if (t == 20) cont = 1'b0;
    end
    cc1 = 16'd2;
    cont = 1'b1; start = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      @(posedge clk);
      exp = model(t, LC, 3, DC, m, cc1);
      n_checks++;
      if (obs1 !== exp) $display("FAIL stop_in_done t=%0d got %h expected %h", t, obs1, exp);
      else n_pass++;
      start = 1'b0;
      stop  = (t == 16);
    end
    cont = 1'b0;
  endtask

  task automatic test_no_phases;
    logic [26:0] exp;
    int          r;
    logic [3:0]  m;
    for (int k = 0; k < 2; k++) begin
      r = int'($urandom_range(1, 6));
      m = 4'($urandom_range(1, 15));
      rl = 16'(r); mask = m; start2 = 1'b1;
      for (int t = 1; t <= r + 3; t++) begin
        @(posedge clk);
        exp = model(t, 0, r, 0, m, cc2);
        n_checks++;
        if (obs2 !== exp) $display("FAIL nophase k=%0d t=%0d got %h expected %h", k, t, obs2, exp);
        else n_pass++;
        start2 = 1'b0;
      end
      cc2 = 16'(r - 1);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [26:0] exp;
    logic [3:0]  m;
    m = 4'($urandom_range(1, 15));
    rl = 16'd20; mask = m; start = 1'b1;
    for (int t = 1; t <= LC + 7; t++) begin
      @(posedge clk);
      exp = model(t, LC, 20, DC, m, cc1);
      n_checks++;
      if (obs1 !== exp) $display("FAIL reset_prerun t=%0d got %h expected %h", t, obs1, exp);
      else n_pass++;
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs1 !== 27'd0) $display("FAIL reset_midrun got %h expected %h", obs1, 27'd0);
    else n_pass++;
    #1 rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      n_checks++;
      if (obs1 !== 27'd0) $display("FAIL reset_release t=%0d got %h expected %h", t, obs1, 27'd0);
      else n_pass++;
    end
    cc1 = '0;
    cc2 = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_runs();
    test_stop_run();
    test_invalid_start();
    test_continuous();
    test_no_phases();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
